// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, CSR write targets
// and mstatus field positions.
package trap_sequencer_pkg;

  localparam int CAUSE_ILLEGAL_INSTR = 2;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_HI = 12;
  localparam int MPP_LO = 11;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    REDIRECT
  } trapState_;

  // NONE is what the port shows while the sequencer does not own it.
  typedef enum logic [11:0] {
    NONE    = 12'h000,
    MSTATUS = 12'h300,
    MEPC    = 12'h341,
    MCAUSE  = 12'h342,
    MTVAL   = 12'h343
  } destinationCSR_;

endpackage

// File: rtl/trap_sequencer_if.sv
// Writeback-side bundle of the trap sequencer: retiring-instruction status and CSR
// snapshots in, commit kill / stall / CSR write / fetch redirect out.
interface trap_sequencer_if
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic             wbValid;
  logic             wbIllegal;
  logic             wbMret;
  logic [XLEN-1:0]  wbPC;
  logic [XLEN-1:0]  wbInstr;
  logic             interrupt;
  logic [XLEN-1:0]  mstatusIn;
  logic [XLEN-1:0]  mtvecIn;
  logic [XLEN-1:0]  mepcIn;

  logic             suppressCommit;
  logic             stall;
  logic             portGrant;
  logic             csrEnable;
  destinationCSR_   csrAddr;
  logic [XLEN-1:0]  csrData;
  logic             flush;
  logic             redirectValid;
  logic [XLEN-1:0]  redirectPC;

  modport master (
    output wbValid, wbIllegal, wbMret, wbPC, wbInstr, interrupt,
           mstatusIn, mtvecIn, mepcIn,
    input  suppressCommit, stall, portGrant, csrEnable, csrAddr, csrData,
           flush, redirectValid, redirectPC
  );

  modport slave (
    input  wbValid, wbIllegal, wbMret, wbPC, wbInstr, interrupt,
           mstatusIn, mtvecIn, mepcIn,
    output suppressCommit, stall, portGrant, csrEnable, csrAddr, csrData,
           flush, redirectValid, redirectPC
  );

endinterface

// File: rtl/trap_sequencer.sv
// Takes traps/MRET at writeback: kills the commit, writes mepc/mcause/mtval/mstatus one
// per cycle, then flushes and redirects fetch (trap: redirect 5 cycles after detect, MRET: 2).
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int EXT_INT_CAUSE = 11,
  parameter bit VECTORED_EN   = 1'b1
) (
  input logic             clock,
  input logic             reset,
  trap_sequencer_if.slave bus
);

  localparam logic [XLEN-1:0] INT_CAUSE  = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(EXT_INT_CAUSE);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] VEC_OFFSET = XLEN'(4 * EXT_INT_CAUSE);

  trapState_       state;
  logic [XLEN-1:0] capPC, capCause, capMtval, capStatus;
  logic            capInt, capMret;
  logic            intTake, excTake, retTake, anyTake;
  logic [XLEN-1:0] trapStatus, retStatus, vecBase;

  // Gated by reset so nothing leaks out combinationally while reset is held.
  always_comb begin
    intTake = !reset && (state == IDLE) && bus.wbValid && bus.interrupt && bus.mstatusIn[MIE];
    excTake = !reset && (state == IDLE) && bus.wbValid && bus.wbIllegal;
    retTake = !reset && (state == IDLE) && bus.wbValid && bus.wbMret && !bus.wbIllegal;
    anyTake = intTake || excTake || retTake;
  end

  always_comb begin
    trapStatus                = capStatus;
    trapStatus[MPIE]          = capStatus[MIE];
    trapStatus[MIE]           = 1'b0;
    trapStatus[MPP_HI:MPP_LO] = 2'b11;
    retStatus                 = capStatus;
    retStatus[MIE]            = capStatus[MPIE];
    retStatus[MPIE]           = 1'b1;
    retStatus[MPP_HI:MPP_LO]  = 2'b11;
    vecBase                   = bus.mtvecIn & ALIGN_MASK;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      capPC     <= '0;
      capCause  <= '0;
      capMtval  <= '0;
      capStatus <= '0;
      capInt    <= 1'b0;
      capMret   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyTake) begin
            capPC     <= bus.wbPC;
            capStatus <= bus.mstatusIn;
            capInt    <= intTake;
            capMret   <= !intTake && !excTake;
            capCause  <= intTake ? INT_CAUSE : XLEN'(CAUSE_ILLEGAL_INSTR);
            capMtval  <= intTake ? '0 : bus.wbInstr;
            state     <= (intTake || excTake) ? WR_MEPC : WR_MSTATUS;
          end
        end
        WR_MEPC:    state <= WR_MCAUSE;
        WR_MCAUSE:  state <= WR_MTVAL;
        WR_MTVAL:   state <= WR_MSTATUS;
        WR_MSTATUS: state <= REDIRECT;
        default:    state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.suppressCommit = 1'b0;
    bus.stall          = 1'b0;
    bus.portGrant      = 1'b0;
    bus.csrEnable      = 1'b0;
    bus.csrAddr        = NONE;
    bus.csrData        = '0;
    bus.flush          = 1'b0;
    bus.redirectValid  = 1'b0;
    bus.redirectPC     = '0;
    case (state)
      IDLE: begin
        bus.suppressCommit = anyTake;
        bus.stall          = anyTake;
      end
      WR_MEPC: begin
        {bus.stall, bus.portGrant, bus.csrEnable} = 3'b111;
        bus.csrAddr = MEPC;
        bus.csrData = capPC & ALIGN_MASK;
      end
      WR_MCAUSE: begin
        {bus.stall, bus.portGrant, bus.csrEnable} = 3'b111;
        bus.csrAddr = MCAUSE;
        bus.csrData = capCause;
      end
      WR_MTVAL: begin
        {bus.stall, bus.portGrant, bus.csrEnable} = 3'b111;
        bus.csrAddr = MTVAL;
        bus.csrData = capMtval;
      end
      WR_MSTATUS: begin
        {bus.stall, bus.portGrant, bus.csrEnable} = 3'b111;
        bus.csrAddr = MSTATUS;
        bus.csrData = capMret ? retStatus : trapStatus;
      end
      REDIRECT: begin
        bus.stall         = 1'b1;
        bus.flush         = 1'b1;
        bus.redirectValid = 1'b1;
        if (capMret)
          bus.redirectPC = bus.mepcIn;
        else if (VECTORED_EN && capInt && (bus.mtvecIn[1:0] == 2'b01))
          bus.redirectPC = vecBase + VEC_OFFSET;
        else
          bus.redirectPC = vecBase;
      end
      default: ;
    endcase
  end

endmodule
